// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the ALU issue bundle handed from the issue stage to the ALU.
package rv32i_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      op;
    logic            sub;
    logic [4:0]      rd;
    logic            illegal;
  } alu_bundle_t;
endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of OP, OP-IMM, LUI and AUIPC into an ALU bundle.
module alu_issue_decode
  import rv32i_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_bundle_t   bundle
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    bundle = '0;
    legal  = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        legal = (funct7 == FUNCT7_BASE) ||
                ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        bundle.a   = rs1_data;
        bundle.b   = rs2_data;
        bundle.op  = funct3;
        bundle.sub = instr[30];
      end
      OPCODE_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == FUNCT7_BASE);
          3'b101:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default: legal = 1'b1;
        endcase
        bundle.a   = rs1_data;
        bundle.b   = imm_i;
        bundle.op  = funct3;
        // Only shifts treat bit 30 as a control; for ADDI etc. it is immediate data.
        bundle.sub = (funct3 == 3'b101) ? instr[30] : 1'b0;
      end
      OPCODE_LUI: begin
        legal    = 1'b1;
        bundle.b = imm_u;
      end
      OPCODE_AUIPC: begin
        legal    = 1'b1;
        bundle.a = pc;
        bundle.b = imm_u;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      bundle.rd = instr[11:7];
    end else begin
      bundle         = '0;
      bundle.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a two-entry (main + skid) output buffer with registered in_ready.
module alu_issue_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      op,
  output logic            subtract_or_arithmetic_shift,
  output logic [4:0]      rd,
  output logic            illegal
);
  alu_bundle_t decoded;
  alu_bundle_t main_reg;
  alu_bundle_t skid_reg;
  logic        main_valid;
  logic        skid_valid;
  logic        accept;
  logic        drain;

  alu_issue_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (decoded)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_reg   <= '0;
      skid_reg   <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so the only possible move is skid -> main.
      if (drain) begin
        main_reg   <= skid_reg;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_reg   <= decoded;
        main_valid <= 1'b1;
      end else begin
        skid_reg   <= decoded;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  assign out_valid                    = main_valid;
  assign a                            = main_reg.a;
  assign b                            = main_reg.b;
  assign op                           = main_reg.op;
  assign subtract_or_arithmetic_shift = main_reg.sub;
  assign rd                           = main_reg.rd;
  assign illegal                      = main_reg.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, random traffic against a queue model, corner sequences.
module tb_alu_issue_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sub;
  logic [4:0]  rd;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;
  alu_bundle_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .op(op),
    .subtract_or_arithmetic_shift(sub), .rd(rd), .illegal(illegal)
  );

  function automatic alu_bundle_t got_bundle();
    return '{a: a, b: b, op: op, sub: sub, rd: rd, illegal: illegal};
  endfunction

  // Reference decode, written straight from the instruction-set rules.
  function automatic alu_bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                             input logic [31:0] r1, input logic [31:0] r2);
    alu_bundle_t r;
    int  f3  = int'(ins[14:12]);
    int  f7  = int'(ins[31:25]);
    int  opc = int'(ins[6:0]);
    logic ok = 1'b0;
    logic [31:0] immi = 32'(signed'(ins[31:20]));
    logic [31:0] immu = ins[31:12] << 12;
    r = '0;
    if (opc == 'h33) begin
      ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      r = '{a: r1, b: r2, op: ins[14:12], sub: ins[30], rd: ins[11:7], illegal: 1'b0};
    end else if (opc == 'h13) begin
      ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
      r = '{a: r1, b: immi, op: ins[14:12], sub: (f3 == 5) && ins[30], rd: ins[11:7], illegal: 1'b0};
    end else if (opc == 'h37) begin
      ok = 1'b1;
      r = '{a: 0, b: immu, op: 0, sub: 0, rd: ins[11:7], illegal: 1'b0};
    end else if (opc == 'h17) begin
      ok = 1'b1;
      r = '{a: p, b: immu, op: 0, sub: 0, rd: ins[11:7], illegal: 1'b0};
    end
    if (!ok) begin
      r = '0;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle at the negedge: check state against model, drive inputs, advance model.
  task automatic step(input logic v, input logic ordy, input logic fl,
                      input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2, output logic took);
    logic fire_in, fire_out;
    chk("out_valid", 74'(out_valid), 74'(q.size() > 0));
    chk("in_ready", 74'(in_ready), 74'(q.size() < 2));
    if (q.size() > 0) chk("bundle", got_bundle(), q[0]);
    in_valid = v; out_ready = ordy; flush = fl;
    instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    fire_in  = v && (q.size() < 2) && !fl;
    fire_out = (q.size() > 0) && ordy;
    took = fire_in;
    $display("cyc v=%0b rdy=%0b fl=%0b instr=%h q=%0d in=%0b out=%0b",
             v, ordy, fl, ins, q.size(), fire_in, fire_out);
    if (fl) q.delete();
    else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(ref_decode(ins, p, r1, r2));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0] opcs [5] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03};
    logic [6:0] f7s  [4] = '{7'h00, 7'h20, 7'h00, 7'h7f};
    w[6:0] = opcs[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] p;
    logic [31:0] r1;
    logic [31:0] r2;
    alu_bundle_t exp;
  } vec_t;

  vec_t tbl [10];
  logic took;

  initial begin
    tbl[0] = '{32'hFFF10093, 32'h0, 32'd5, 32'd9,   '{32'd5, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd1, 1'b0}};
    tbl[1] = '{32'h405201B3, 32'h0, 32'd10, 32'd3,  '{32'd10, 32'd3, 3'd0, 1'b1, 5'd3, 1'b0}};
    tbl[2] = '{32'h4030D093, 32'h0, 32'h80000000, 32'd1, '{32'h80000000, 32'h403, 3'd5, 1'b1, 5'd1, 1'b0}};
    tbl[3] = '{32'h123452B7, 32'h40, 32'd7, 32'd8,  '{32'd0, 32'h12345000, 3'd0, 1'b0, 5'd5, 1'b0}};
    tbl[4] = '{32'h00001097, 32'h100, 32'd7, 32'd8, '{32'h100, 32'h1000, 3'd0, 1'b0, 5'd1, 1'b0}};
    tbl[5] = '{32'h40101093, 32'h0, 32'd7, 32'd8,   '{32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b1}};
    tbl[6] = '{32'h00002083, 32'h0, 32'd7, 32'd8,   '{32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b1}};
    tbl[7] = '{32'h4001C113, 32'h0, 32'd7, 32'd8,   '{32'd7, 32'h400, 3'd4, 1'b0, 5'd2, 1'b0}};
    tbl[8] = '{32'h4083D333, 32'h0, 32'hF0, 32'd4,  '{32'hF0, 32'd4, 3'd5, 1'b1, 5'd6, 1'b0}};
    tbl[9] = '{32'h40001033, 32'h0, 32'd7, 32'd8,   '{32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b1}};

    // Reset state, checked while reset is still asserted.
    repeat (2) @(negedge clk);
    chk("reset out_valid", 74'(out_valid), 74'(0));
    chk("reset in_ready", 74'(in_ready), 74'(1));
    chk("reset bundle", got_bundle(), 74'(0));
    reset = 1'b0;
    @(negedge clk);

    // Decode table: one instruction per cycle, checked one cycle later against constants.
    foreach (tbl[i]) begin
      step(1'b1, 1'b1, 1'b0, tbl[i].ins, tbl[i].p, tbl[i].r1, tbl[i].r2, took);
      chk($sformatf("vec%0d valid", i), 74'(out_valid), 74'(1));
      chk($sformatf("vec%0d bundle", i), got_bundle(), tbl[i].exp);
    end
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, took);

    // Backpressure: offer 4 with out_ready low for 3 cycles, then release.
    begin
      int sent = 0;
      for (int c = 0; c < 12; c++) begin
        step(sent < 4, c >= 3, 1'b0, 32'h00000093 | (32'(sent + 1) << 7) | (32'(sent) << 20),
             0, 32'd100, 0, took);
        if (took) sent++;
        if (c == 2) chk("bp accepted", 74'(sent), 74'(2));
      end
      chk("bp all sent", 74'(sent), 74'(4));
    end

    // Flush with both entries full and input offered.
    step(1'b1, 1'b0, 1'b0, 32'h00100113, 0, 1, 0, took);
    step(1'b1, 1'b0, 1'b0, 32'h00200113, 0, 2, 0, took);
    step(1'b1, 1'b1, 1'b1, 32'h00300113, 0, 3, 0, took);
    chk("flush out_valid", 74'(out_valid), 74'(0));
    chk("flush in_ready", 74'(in_ready), 74'(1));
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, took);

    // Asynchronous reset in the middle of traffic.
    step(1'b1, 1'b0, 1'b0, 32'h123452B7, 0, 0, 0, took);
    step(1'b1, 1'b0, 1'b0, 32'hFFF10093, 0, 5, 0, took);
    #2 reset = 1'b1;
    #1;
    chk("midreset out_valid", 74'(out_valid), 74'(0));
    chk("midreset in_ready", 74'(in_ready), 74'(1));
    chk("midreset bundle", got_bundle(), 74'(0));
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
           rand_instr(), $urandom, $urandom, $urandom, took);
    end
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, took);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
